// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch into an in-order FIFO,
// with a redirect flush that discards both queued words and words still in flight.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        IFQ_valid,
  output logic [31:0] IFQ_Instr,
  output logic [31:0] IFQ_PC,
  input  logic        DU_ready
);
  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_S = {1'b0, DEPTH_C};

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] ifl_rd_q, ifl_rd_d, ifl_wr_q, ifl_wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   ifl_pc_q     [DEPTH];

  logic [CW:0]   credit_used;
  logic [CW:0]   drop_sum;
  logic          issue;
  logic          ret_any;
  logic          ret_drop;
  logic          ret_push;
  logic          deq;

  // Slots already promised (queued + in flight) gate new requests, so a return never finds the FIFO full.
  assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req    = rst_n & ~redirect_valid & (credit_used < DEPTH_S);
  assign imem_addr   = fetch_pc_q;
  assign issue       = imem_req & imem_ready;

  assign ret_drop = imem_rvalid & (drop_q != '0);
  assign ret_any  = imem_rvalid & ((drop_q != '0) | (outst_q != '0));
  assign ret_push = imem_rvalid & (drop_q == '0) & (outst_q != '0) & ~redirect_valid;

  assign IFQ_valid = rst_n & (count_q != '0);
  assign IFQ_Instr = IFQ_valid ? fifo_instr_q[rd_ptr_q] : NOP;
  assign IFQ_PC    = IFQ_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
  assign deq       = IFQ_valid & DU_ready & ~redirect_valid;

  // A return arriving in the redirect cycle is consumed here, so it must not be counted as still owed.
  assign drop_sum = {1'b0, drop_q} + {1'b0, outst_q} - (CW+1)'(ret_any);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ifl_rd_d   = ifl_rd_q;
    ifl_wr_d   = ifl_wr_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      ifl_rd_d   = '0;
      ifl_wr_d   = '0;
      count_d    = '0;
      outst_d    = '0;
      drop_d     = drop_sum[CW-1:0];
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        ifl_wr_d   = ifl_wr_q + 1'b1;
      end
      if (ret_push) begin
        ifl_rd_d = ifl_rd_q + 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(ret_push) - CW'(deq);
      outst_d = outst_q + CW'(issue) - CW'(ret_push);
      drop_d  = drop_q - CW'(ret_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ifl_rd_q   <= '0;
      ifl_wr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ifl_rd_q   <= ifl_rd_d;
      ifl_wr_q   <= ifl_wr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Storage arrays carry no reset; occupancy counters alone define what is valid.
  always_ff @(posedge clk) begin
    if (issue) begin
      ifl_pc_q[ifl_wr_q] <= fetch_pc_q;
    end
    if (ret_push) begin
      fifo_pc_q[wr_ptr_q]    <= ifl_pc_q[ifl_rd_q];
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rvalid && (drop_q == '0) && (outst_q == '0)));
      assert (!(ret_push && (count_q == DEPTH_C) && !deq));
      assert (!redirect_valid || (drop_sum <= DEPTH_S));
    end
  end

endmodule
